// File: rtl/mont_pkg.sv
// Shared constants and FSM encoding for the pointwise-multiply path
// (pointwise_mul_feeder and montgomery_reduce).
package mont_pkg;

  localparam int unsigned Q      = 7681;
  localparam int unsigned COEF_W = 13;
  localparam int unsigned PROD_W = 2 * COEF_W;
  localparam int unsigned N      = 256;
  localparam int unsigned ADDR_W = $clog2(N);

  // Modulus at coefficient width, for range comparisons without widening.
  localparam logic [COEF_W-1:0] QCoef = COEF_W'(Q);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  // True when a coefficient is a valid residue mod Q.
  function automatic logic coef_in_range(input logic [COEF_W-1:0] c);
    return c < QCoef;
  endfunction

endpackage

// File: rtl/coef_mul_pipe.sv
// Registered coefficient multiplier with valid/index sideband.
// Stage 1 captures the operands; the product lands in the output stage.
// With POINTWISE_MUL_PIPE2_EN defined, an extra register sits between the
// multiplier and the output stage (latency +1, throughput unchanged).
module coef_mul_pipe
  import mont_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_idx,
  input  logic [COEF_W-1:0] in_a,
  input  logic [COEF_W-1:0] in_b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic [PROD_W-1:0] out_prod,
  output logic              pipe_busy
);

  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
  logic [COEF_W-1:0] s1_a_q, s1_a_d;
  logic [COEF_W-1:0] s1_b_q, s1_b_d;

  logic              o_vld_q, o_vld_d;
  logic [ADDR_W-1:0] o_idx_q, o_idx_d;
  logic [PROD_W-1:0] o_prod_q, o_prod_d;

  logic [PROD_W-1:0] mul_c;
  // Source feeding the output stage (multiplier or its retiming register).
  logic              src_vld;
  logic [ADDR_W-1:0] src_idx;
  logic [PROD_W-1:0] src_prod;

  // Full-width unsigned product; (Q-1)^2 fits in PROD_W bits.
  assign mul_c = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);

  // Stage 1 next state: operands only load on a valid beat.
  always_comb begin
    s1_vld_d = in_valid;
    s1_idx_d = s1_idx_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (in_valid) begin
      s1_idx_d = in_idx;
      s1_a_d   = in_a;
      s1_b_d   = in_b;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
    end
  end

`ifdef POINTWISE_MUL_PIPE2_EN
  logic              s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0] s2_idx_q, s2_idx_d;
  logic [PROD_W-1:0] s2_prod_q, s2_prod_d;

  // Retiming stage next state after the multiplier.
  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_idx_d  = s2_idx_q;
    s2_prod_d = s2_prod_q;
    if (s1_vld_q) begin
      s2_idx_d  = s1_idx_q;
      s2_prod_d = mul_c;
    end
  end

  // Retiming stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_idx_q  <= '0;
      s2_prod_q <= '0;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_idx_q  <= s2_idx_d;
      s2_prod_q <= s2_prod_d;
    end
  end

  // Output stage fed from the retiming register.
  always_comb begin
    src_vld   = s2_vld_q;
    src_idx   = s2_idx_q;
    src_prod  = s2_prod_q;
    pipe_busy = s1_vld_q | s2_vld_q;
  end
`else
  // Output stage fed straight from the multiplier.
  always_comb begin
    src_vld   = s1_vld_q;
    src_idx   = s1_idx_q;
    src_prod  = mul_c;
    pipe_busy = s1_vld_q;
  end
`endif

  // Output stage next state: data holds its last value on idle cycles.
  always_comb begin
    o_vld_d  = src_vld;
    o_idx_d  = o_idx_q;
    o_prod_d = o_prod_q;
    if (src_vld) begin
      o_idx_d  = src_idx;
      o_prod_d = src_prod;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q  <= 1'b0;
      o_idx_q  <= '0;
      o_prod_q <= '0;
    end else begin
      o_vld_q  <= o_vld_d;
      o_idx_q  <= o_idx_d;
      o_prod_q <= o_prod_d;
    end
  end

  assign out_valid = o_vld_q;
  assign out_idx   = o_idx_q;
  assign out_prod  = o_prod_q;

endmodule

// File: rtl/pointwise_mul_feeder.sv
// Streams N coefficient pairs from RAMs A/B through coef_mul_pipe and emits
// one product strobe per index, in order, for montgomery_reduce.
// Optional macro POINTWISE_MUL_PIPE2_EN adds a multiplier retiming stage
// (rd_en to prod_valid latency 4 instead of 3).
module pointwise_mul_feeder
  import mont_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] rd_data_a,
  input  logic [COEF_W-1:0] rd_data_b,
  output logic [PROD_W-1:0] prod,
  output logic              prod_valid,
  output logic [ADDR_W-1:0] prod_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  // Marks the cycle in which RAM data for an issued read is present.
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

  logic              issue_c;
  logic              pipe_busy;
  logic              start_ok;

  assign start_ok = (state_q == IDLE) && start;

  // FSM and address counter next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue_c = 1'b1;
          if (cnt_q == LastAddr) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      // The output stage is excluded so done lands right after the last product.
      DRAIN: begin
        if (!rd_vld_q && !pipe_busy) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read-return tracking and sticky range-error flag next state.
  always_comb begin
    rd_vld_d = issue_c;
    rd_idx_d = issue_c ? cnt_q : rd_idx_q;
    err_d    = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end else if (rd_vld_q &&
                 (!coef_in_range(rd_data_a) || !coef_in_range(rd_data_b))) begin
      err_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  coef_mul_pipe u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_vld_q),
    .in_idx    (rd_idx_q),
    .in_a      (rd_data_a),
    .in_b      (rd_data_b),
    .out_valid (prod_valid),
    .out_idx   (prod_idx),
    .out_prod  (prod),
    .pipe_busy (pipe_busy)
  );

  assign rd_en   = issue_c;
  assign rd_addr = cnt_q;
  assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign done    = (state_q == FIN);
  assign err     = err_q;

endmodule

// File: tb/tb_pointwise_mul_feeder.sv
// Scoreboard bench for pointwise_mul_feeder: each run pushes its expected
// (index, product) stream; a negedge monitor pops and compares every strobe.
module tb_pointwise_mul_feeder;
  import mont_pkg::*;

`ifdef POINTWISE_MUL_PIPE2_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COEF_W-1:0] rd_data_a = '0;
  logic [COEF_W-1:0] rd_data_b = '0;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic [ADDR_W-1:0] prod_idx;
  logic              busy;
  logic              done;
  logic              err;

  pointwise_mul_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_idx   (prod_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM models.
  logic [COEF_W-1:0] mem_a [N];
  logic [COEF_W-1:0] mem_b [N];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [PROD_W-1:0] prod;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-run statistics gathered by the monitor.
  int first_rd, last_rd, rd_cnt;
  int first_pv, last_pv, pv_cnt;
  int done_cnt, err_rise;
  logic err_prev = 1'b0;
  logic err_at_done;
  logic [ADDR_W-1:0] last_idx;
  int prod_at [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy && !done) begin
        first_rd = -1; last_rd = -1; rd_cnt = 0;
        first_pv = -1; last_pv = -1; pv_cnt = 0;
        done_cnt = 0; err_rise = -1;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        rd_cnt++;
      end
      if (prod_valid) begin
        if (first_pv < 0) first_pv = cyc;
        last_pv = cyc;
        pv_cnt++;
        last_idx = prod_idx;
        prod_at[prod_idx] = int'(prod);
        if (exp_q.size() == 0) begin
          check("spurious_prod_valid", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          checks++;
          if (prod_idx !== e_mon.idx || prod !== e_mon.prod) begin
            errors++;
            $display("FAIL product: got idx %0d prod %0d, expected idx %0d prod %0d",
                     prod_idx, prod, e_mon.idx, e_mon.prod);
          end
        end
      end
      if (done) begin
        done_cnt++;
        err_at_done = err;
        check("done_one_after_last", cyc - last_pv, 1);
        check("done_last_idx", longint'(last_idx), N - 1);
        check("busy_low_at_done", longint'(busy), 0);
      end
      if (err && !err_prev && err_rise < 0) err_rise = cyc;
      err_prev = err;
    end else begin
      err_prev = 1'b0;
    end
  end

  task automatic load_expected();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      e.idx  = ADDR_W'(i);
      e.prod = PROD_W'(mem_a[i]) * PROD_W'(mem_b[i]);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    load_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One full run with optional hold window, stray start pulses and end checks.
  task automatic run_scn(input string tag, input int hold_at, input int start_at,
                         input bit start_fin, input int exp_gaps, input bit chk_err_clr);
    int  hold_cnt;
    bit  hold_done, sa_done, seen;
    hold_cnt = 0; hold_done = 0; sa_done = 0; seen = 0;
    do_start();
    if (chk_err_clr) check({tag, "_err_cleared_on_start"}, longint'(err), 0);
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (seen) break;
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) hold = 1'b0;
      end else if (!hold_done && hold_at >= 0 && busy && rd_addr == ADDR_W'(hold_at)) begin
        hold = 1'b1; hold_cnt = 5; hold_done = 1;
      end
      if (!sa_done && start_at >= 0 && busy && rd_addr == ADDR_W'(start_at)) begin
        start = 1'b1; sa_done = 1;
      end
      if (done) begin
        seen = 1;
        if (start_fin) start = 1'b1;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    if (!seen) check({tag, "_timeout_waiting_done"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_prod_valid_count"}, pv_cnt, N);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_rd_en_count"}, rd_cnt, N);
    check({tag, "_rd_span"}, last_rd - first_rd + 1, N + exp_gaps);
    check({tag, "_latency"}, first_pv - first_rd, Lat);
    check({tag, "_prod_gaps"}, last_pv - first_pv + 1 - pv_cnt, exp_gaps);
    check({tag, "_idle_after"}, longint'({busy, rd_en, done}), 0);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        mem_a[i] = COEF_W'(i); mem_b[i] = COEF_W'(2);
      end else begin
        mem_a[i] = COEF_W'(7680); mem_b[i] = COEF_W'(7680);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          longint'({rd_en, rd_addr, prod, prod_valid, prod_idx, busy, done, err}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // A[i]=i, B[i]=2: prod = 2i.
    run_scn("ramp", -1, -1, 1'b0, 0, 1'b0);
    check("ramp_prod_255", prod_at[255], 510);
    check("ramp_prod_100", prod_at[100], 200);
    check("ramp_err", longint'(err), 0);

    // Maximum operands: (Q-1)^2 = 58982400.
    fill(1);
    run_scn("max", -1, -1, 1'b0, 0, 1'b0);
    check("max_prod_0", prod_at[0], 58982400);
    check("max_prod_255", prod_at[255], 58982400);
    check("max_err_never", err_rise, -1);

    // Out-of-range A[17]: err rises 2 cycles after its read, sticky.
    mem_a[17] = COEF_W'(7681);
    run_scn("range", -1, -1, 1'b0, 0, 1'b0);
    check("range_err_rise", err_rise - first_rd, 19);
    check("range_err_at_done", longint'(err_at_done), 1);
    check("range_err_sticky", longint'(err), 1);
    check("range_prod_17", prod_at[17], 58990080);

    // Hold for 5 cycles at address 100; err cleared by the accepted start.
    fill(0);
    run_scn("hold", 100, -1, 1'b0, 5, 1'b1);
    check("hold_prod_101", prod_at[101], 202);

    // Stray starts mid-run and in FIN are ignored.
    run_scn("stray", -1, 50, 1'b1, 0, 1'b0);

    // Asynchronous reset at address 128.
    do_start();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (busy && rd_addr == ADDR_W'(128)) break;
    end
    check("abort_reached_128", longint'(rd_addr), 128);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs_zero",
          longint'({rd_en, rd_addr, prod, prod_valid, prod_idx, busy, done, err}), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", longint'({busy, prod_valid, rd_en}), 0);
    run_scn("post_abort", -1, -1, 1'b0, 0, 1'b0);
    check("post_abort_prod_128", prod_at[128], 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pointwise_mul_feeder.md
Name: pointwise_mul_feeder

Overview:
- Upstream neighbour of montgomery_reduce in the pointwise-multiply path.
- On start, streams N coefficient pairs out of two coefficient RAMs (A, B) and multiplies each pair in a short pipeline.
- Each 26-bit product is presented with a one-cycle strobe, ready to drive montgomery_reduce X/en directly.
- Downstream has no backpressure, so every product is emitted exactly once, in index order.

Parameters:
- Q, 7681, modulus; every input coefficient must be < Q.
- COEF_W, 13, coefficient width.
- PROD_W, 26, product width; fixed at 2*COEF_W.
- N, 256, coefficients per polynomial.
- ADDR_W, 8, RAM address width; fixed at clog2(N).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to process a polynomial pair.
- hold  in  1  pauses read issue while high.
- rd_en  out  1  read strobe to both RAMs.
- rd_addr  out  ADDR_W  common read address for both RAMs.
- rd_data_a  in  COEF_W  RAM A data, valid 1 cycle after rd_en.
- rd_data_b  in  COEF_W  RAM B data, valid 1 cycle after rd_en.
- prod  out  PROD_W  product a*b; drives montgomery_reduce X.
- prod_valid  out  1  product strobe; drives montgomery_reduce en.
- prod_idx  out  ADDR_W  coefficient index of prod.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last product.
- err  out  1  sticky flag: a coefficient >= Q was read.

Behaviour:
- Reset: all outputs 0, state IDLE, address counter 0, pipeline valid bits 0.
- Reset mid-operation aborts immediately. No done pulse is generated and no further prod_valid is issued.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: if start=1, go to ISSUE next cycle, set busy=1, clear err, set address counter to 0.
- ISSUE, hold=0: rd_en=1, rd_addr=counter, counter increments. After issuing address N-1, go to DRAIN.
- ISSUE, hold=1: rd_en=0 and counter is frozen. Already-issued reads keep flowing, so bubbles appear on prod_valid.
- DRAIN: no reads. Wait until every pipeline valid bit is 0, then go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- start while busy: ignored. start in the FIN cycle: also ignored.
- Pipeline, for a read issued in cycle t:
  - t+1: RAM data returns and is registered into stage 1 with valid and index.
  - t+2: COEF_W x COEF_W unsigned multiply, registered into the output stage.
  - t+3: prod, prod_valid, prod_idx visible.
- Latency from rd_en to prod_valid is 3 cycles. Continuous issue gives one product per cycle.
- Width rule: the product is a full unsigned PROD_W value with no truncation. Maximum (Q-1)^2 = 58982400 < 2^26.
- When prod_valid=0, prod and prod_idx hold their last values.
- Range check: if stage-1 a >= Q or b >= Q, set err on the next cycle. err stays set until the next accepted start. The product is still emitted.
- Wrap-around: the counter never wraps inside one run. The ISSUE-to-DRAIN exit fires on counter == N-1 with hold=0.
- Simultaneous hold and the last issue: the last address is issued only when hold=0.

Optional Feature:
- Macro: POINTWISE_MUL_PIPE2_EN.
- Defined: adds one register stage after the multiplier (multiply split for timing). Latency becomes 4 cycles. DRAIN waits on the extra valid bit. Throughput is unchanged.
- Undefined: latency is 3 cycles as above.

Decomposition:
- Package mont_pkg holds:
  - Q, COEF_W, PROD_W, N, ADDR_W;
  - the FSM state enum {IDLE, ISSUE, DRAIN, FIN}.
- montgomery_reduce and this block share the package, so widths stay consistent.
- Sub-module coef_mul_pipe: registered multiplier with valid and index sideband. The PIPE2 option lives inside it.
- The top level keeps the FSM, address counter, range check and done logic.

Test Plan:
- Reset, then start with A[i]=i and B[i]=2.
  - rd_en high for 256 consecutive cycles; first prod_valid 3 cycles after the first rd_en.
  - prod = 2i for prod_idx = i.
  - done pulses exactly once, the cycle after prod_idx=255; busy falls with done.
- A[i]=B[i]=7680 for all i -> every prod = 58982400 (0x3840000), err stays 0.
- Same run with A[17]=7681 -> err rises 2 cycles after the rd_en for address 17, stays high through done, and clears on the next start. Product at idx 17 = 7681*B[17].
- hold high for 5 cycles at address 100 -> exactly 5 prod_valid gaps. Index sequence stays contiguous 0..255 with no duplicates; total prod_valid count = 256.
- start pulsed again at address 50 and in the FIN cycle -> both ignored; counter and outputs unaffected.
- rst_n low at address 128 -> all outputs 0 asynchronously. No done pulse. After release, the next start gives a clean full run.
- Rerun all scenarios with POINTWISE_MUL_PIPE2_EN defined -> latency 4, results otherwise identical.
